// File: rtl/conv_core_ctrl.sv
// MAC core sequencer for one conv/FC layer: walks output positions and kernel elements,
// issues source/parameter read addresses with k_init/k_fin framing, pulses s_fin at frame end.
module conv_core_ctrl #(
   parameter int AW = 12,
   parameter int PW = 10,
   parameter int CW = 4,
   parameter int XW = 5
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_s_init,
   input  logic          i_out_busy,
   input  logic          i_backprop,
   input  logic [CW-1:0] i_id,
   input  logic [XW-1:0] i_iw,
   input  logic [AW-1:0] i_cs,
   input  logic [XW-1:0] i_ow,
   input  logic [XW-1:0] i_oh,
   input  logic [XW-1:0] i_fw,
   input  logic [XW-1:0] i_fh,
   input  logic [PW-1:0] i_ks,
   output logic          o_exec,
   output logic [AW-1:0] o_src_a,
   output logic [PW-1:0] o_prm_a,
   output logic          o_k_init,
   output logic          o_k_fin,
   output logic          o_s_fin,
   output logic          o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DONE} state_t;

   localparam logic [AW-1:0] ONE_A = AW'(1);

   state_t        r_state, w_state_nxt;
   logic [XW-1:0] r_fx, r_fy, r_ox, r_oy;
   logic [CW-1:0] r_ic;
   logic [PW-1:0] r_ki;
   logic          r_fin_pos;

   logic          w_issue, w_klast, w_plast;
   logic [AW-1:0] w_src;
   logic [PW-1:0] w_prm;
   logic          w_exec_nxt, w_kinit_nxt, w_kfin_nxt, w_sfin_nxt, w_busy_nxt;
   logic [AW-1:0] w_src_nxt;
   logic [PW-1:0] w_prm_nxt;

   // Counters always point at the element issued on the next exec cycle.
   assign w_issue = ((r_state == S_WAIT) && !i_out_busy) || ((r_state == S_RUN) && !o_k_fin);
   assign w_klast = (r_ki == i_ks);
   assign w_plast = (r_ox == i_ow) && (r_oy == i_oh);

   assign w_src = AW'(r_ic) * i_cs
                + (AW'(r_oy) + AW'(r_fy)) * (AW'(i_iw) + ONE_A)
                + AW'(r_ox) + AW'(r_fx);
   assign w_prm = i_backprop ? (i_ks - r_ki) : r_ki;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (i_s_init)   w_state_nxt = S_WAIT;
         S_WAIT: if (!i_out_busy) w_state_nxt = S_RUN;
         S_RUN:  if (o_k_fin)    w_state_nxt = r_fin_pos ? S_DONE : S_WAIT;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_exec_nxt  = w_issue;
      w_kinit_nxt = w_issue && (r_ki == '0);
      w_kfin_nxt  = w_issue && w_klast;
      w_sfin_nxt  = (w_state_nxt == S_DONE);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_src_nxt   = w_issue ? w_src : o_src_a;
      w_prm_nxt   = w_issue ? w_prm : o_prm_a;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_exec   <= 1'b0;
         o_k_init <= 1'b0;
         o_k_fin  <= 1'b0;
         o_s_fin  <= 1'b0;
         o_busy   <= 1'b0;
         o_src_a  <= '0;
         o_prm_a  <= '0;
      end else begin
         o_exec   <= w_exec_nxt;
         o_k_init <= w_kinit_nxt;
         o_k_fin  <= w_kfin_nxt;
         o_s_fin  <= w_sfin_nxt;
         o_busy   <= w_busy_nxt;
         o_src_a  <= w_src_nxt;
         o_prm_a  <= w_prm_nxt;
      end
   end

   // Kernel nest fx/fy/ic plus linear ki; output nest ox/oy steps on the last kernel element.
   always_ff @(posedge i_clk) begin
      if (i_rst || (r_state == S_IDLE)) begin
         r_fx      <= '0;
         r_fy      <= '0;
         r_ic      <= '0;
         r_ki      <= '0;
         r_ox      <= '0;
         r_oy      <= '0;
         r_fin_pos <= 1'b0;
      end else if (w_issue) begin
         r_fin_pos <= w_klast && w_plast;
         if (w_klast) begin
            r_fx <= '0;
            r_fy <= '0;
            r_ic <= '0;
            r_ki <= '0;
            if (r_ox == i_ow) begin
               r_ox <= '0;
               r_oy <= (r_oy == i_oh) ? '0 : r_oy + 1'b1;
            end else begin
               r_ox <= r_ox + 1'b1;
            end
         end else begin
            r_ki <= r_ki + 1'b1;
            if (r_fx == i_fw) begin
               r_fx <= '0;
               if (r_fy == i_fh) begin
                  r_fy <= '0;
                  r_ic <= (r_ic == i_id) ? '0 : r_ic + 1'b1;
               end else begin
                  r_fy <= r_fy + 1'b1;
               end
            end else begin
               r_fx <= r_fx + 1'b1;
            end
         end
      end
   end

endmodule
